tnoc_packet_unpacker: RTL and testbench

Receive-side flit consumer at a NoC endpoint; sits directly downstream of the router/flit interface. Accepts a valid/ready flit stream, reassembles the multi-flit header into one wide header word, and forwards payload flits in order with a last marker. Optionally checks packet framing and drops malformed packets.

---
 rtl/tnoc_pkg.sv | 51 +++++
 rtl/tnoc_header_assembler.sv | 55 +++++
 rtl/tnoc_packet_unpacker.sv | 241 ++++++++++++++++++++++++
 tb/tb_tnoc_packet_unpacker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnoc_pkg.sv
// Shared types for the NoC endpoint flit unpacker: flit layout, packet types,
// error codes, FSM states and header-flit count helper.
package tnoc_pkg;

  localparam int TNOC_HEADER_WIDTH    = 96;
  localparam int TNOC_FLIT_DATA_WIDTH = 72;
  localparam int TNOC_LENGTH_WIDTH    = 8;
  localparam int TNOC_LENGTH_LSB      = 24;

  typedef enum logic {
    FLIT_HEADER  = 1'b0,
    FLIT_PAYLOAD = 1'b1
  } flit_type_e;

  typedef struct packed {
    flit_type_e                      flit_type;
    logic                            head;
    logic                            tail;
    logic [TNOC_FLIT_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef enum logic [7:0] {
    PKT_READ            = 8'h20,
    PKT_POSTED_WRITE    = 8'h40,
    PKT_NONPOSTED_WRITE = 8'h60,
    PKT_RESPONSE        = 8'h80,
    PKT_RESPONSE_DATA   = 8'hC0
  } packet_type_e;

  typedef enum logic [1:0] {
    ERR_NONE            = 2'd0,
    ERR_UNEXPECTED_HEAD = 2'd1,
    ERR_TYPE_MISMATCH   = 2'd2,
    ERR_TAIL_MISMATCH   = 2'd3
  } error_code_e;

  // DROP only exists when framing checks are built in.
  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_HDR_OUT = 2'd1,
    ST_PAYLOAD = 2'd2
`ifdef TNOC_PACKET_UNPACKER_ERROR_CHECK_EN
    ,ST_DROP   = 2'd3
`endif
  } state_e;

  function automatic int calc_header_flits(input int header_width, input int flit_width);
    return (header_width + flit_width - 1) / flit_width;
  endfunction

endpackage

// File: rtl/tnoc_header_assembler.sv
// Collects header flits into slot positions of one wide header word and tracks
// the slot counter; the word is only written in HEADER, so it holds in HDR_OUT.
module tnoc_header_assembler
  import tnoc_pkg::*;
#(
  parameter int HEADER_WIDTH    = TNOC_HEADER_WIDTH,
  parameter int FLIT_DATA_WIDTH = TNOC_FLIT_DATA_WIDTH,
  parameter int HEADER_FLITS    = calc_header_flits(HEADER_WIDTH, FLIT_DATA_WIDTH),
  parameter int CNT_WIDTH       = $clog2(HEADER_FLITS) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_wr,
  input  logic [FLIT_DATA_WIDTH-1:0] i_data,
  output logic [HEADER_WIDTH-1:0]    o_header,
  output logic [HEADER_WIDTH-1:0]    o_header_next,
  output logic                       o_first_slot,
  output logic                       o_last_slot
);

  logic [CNT_WIDTH-1:0]    r_hdr_cnt;
  logic [HEADER_WIDTH-1:0] r_header;
  logic [HEADER_WIDTH-1:0] w_capture;

  // w_capture is the header as it would look with the current flit in its
  // slot, independent of i_wr, so checks can peek at it without a loop.
  for (genvar k = 0; k < HEADER_FLITS; k++) begin : g_slot
    localparam int LO = k * FLIT_DATA_WIDTH;
    localparam int W  = (HEADER_WIDTH - LO < FLIT_DATA_WIDTH) ? HEADER_WIDTH - LO : FLIT_DATA_WIDTH;
    assign w_capture[LO +: W] = (r_hdr_cnt == CNT_WIDTH'(k)) ? i_data[W-1:0] : r_header[LO +: W];
  end

  assign o_first_slot  = (r_hdr_cnt == '0);
  assign o_last_slot   = (r_hdr_cnt == CNT_WIDTH'(HEADER_FLITS - 1));
  assign o_header      = r_header;
  assign o_header_next = w_capture;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_header <= '0;
    end else if (i_wr) begin
      r_header <= w_capture;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_hdr_cnt <= '0;
    end else if (i_wr) begin
      r_hdr_cnt <= o_last_slot ? '0 : r_hdr_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tnoc_packet_unpacker.sv
// NoC endpoint flit unpacker: header reassembly, zero-latency payload pass-through.
// Define TNOC_PACKET_UNPACKER_ERROR_CHECK_EN to build in framing checks and DROP.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HEADER  | accepting header flits into slots
// ST_HDR_OUT | presenting assembled header, flit input stalled
// ST_PAYLOAD | forwarding payload flits combinationally, counting to length
// ST_DROP    | discarding flits of a malformed packet until tail (check build)
module tnoc_packet_unpacker
  import tnoc_pkg::*;
#(
  parameter int HEADER_WIDTH    = TNOC_HEADER_WIDTH,
  parameter int FLIT_DATA_WIDTH = TNOC_FLIT_DATA_WIDTH,
  parameter int LENGTH_WIDTH    = TNOC_LENGTH_WIDTH,
  parameter int LENGTH_LSB      = TNOC_LENGTH_LSB
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flit_valid,
  output logic                       o_flit_ready,
  input  logic [FLIT_DATA_WIDTH+2:0] i_flit,
  output logic                       o_header_valid,
  input  logic                       i_header_ready,
  output logic [HEADER_WIDTH-1:0]    o_header,
  output logic                       o_payload_valid,
  input  logic                       i_payload_ready,
  output logic [FLIT_DATA_WIDTH-1:0] o_payload,
  output logic                       o_payload_last,
  output logic                       o_error,
  output logic [1:0]                 o_error_code
);

  localparam int HEADER_FLITS = calc_header_flits(HEADER_WIDTH, FLIT_DATA_WIDTH);
  localparam int HDR_CNT_W    = $clog2(HEADER_FLITS) + 1;
  localparam int PAY_CNT_W    = LENGTH_WIDTH + 1;

  state_e r_state;
  state_e w_next;

  logic                       w_flit_type;
  logic                       w_flit_head;
  logic                       w_flit_tail;
  logic [FLIT_DATA_WIDTH-1:0] w_flit_data;

  logic                       w_flit_ready;
  logic                       w_accept;
  logic                       w_bad;
  logic                       w_err;
  state_e                     w_err_dest;

  logic                       w_hdr_wr;
  logic                       w_hdr_clear;
  logic                       w_hdr_first;
  logic                       w_hdr_last;
  logic [HEADER_WIDTH-1:0]    w_header_next;

  logic [PAY_CNT_W-1:0]       r_pay_cnt;
  logic [PAY_CNT_W-1:0]       w_pay_expected;
  logic [LENGTH_WIDTH-1:0]    w_length;
  logic                       w_pay_last;
  logic                       w_pay_xfer;

  assign w_flit_type = i_flit[FLIT_DATA_WIDTH+2];
  assign w_flit_head = i_flit[FLIT_DATA_WIDTH+1];
  assign w_flit_tail = i_flit[FLIT_DATA_WIDTH];
  assign w_flit_data = i_flit[FLIT_DATA_WIDTH-1:0];

  tnoc_header_assembler #(
    .HEADER_WIDTH    (HEADER_WIDTH),
    .FLIT_DATA_WIDTH (FLIT_DATA_WIDTH),
    .HEADER_FLITS    (HEADER_FLITS),
    .CNT_WIDTH       (HDR_CNT_W)
  ) u_hdr (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clear       (w_hdr_clear),
    .i_wr          (w_hdr_wr),
    .i_data        (w_flit_data),
    .o_header      (o_header),
    .o_header_next (w_header_next),
    .o_first_slot  (w_hdr_first),
    .o_last_slot   (w_hdr_last)
  );

  // A zero length field means the full 2**LENGTH_WIDTH payload flits.
  assign w_length       = o_header[LENGTH_LSB +: LENGTH_WIDTH];
  assign w_pay_expected = (w_length == '0) ? PAY_CNT_W'(1 << LENGTH_WIDTH) : PAY_CNT_W'(w_length);
  assign w_pay_last     = (r_pay_cnt == w_pay_expected - 1'b1);

  always_comb begin
    w_flit_ready = 1'b0;
    case (r_state)
      ST_HEADER:  w_flit_ready = 1'b1;
      ST_PAYLOAD: w_flit_ready = i_payload_ready;
`ifdef TNOC_PACKET_UNPACKER_ERROR_CHECK_EN
      ST_DROP:    w_flit_ready = 1'b1;
`endif
      default:    w_flit_ready = 1'b0;
    endcase
  end

  assign w_accept = i_flit_valid && w_flit_ready;

`ifdef TNOC_PACKET_UNPACKER_ERROR_CHECK_EN
  logic        w_check_en;
  logic        w_exp_head;
  logic        w_exp_tail;
  logic        w_exp_type;
  error_code_e w_bad_code;
  logic        r_error;
  error_code_e r_error_code;

  // w_bad depends on the flit only, so payload valid never depends on ready.
  always_comb begin
    w_check_en = 1'b0;
    w_exp_head = 1'b0;
    w_exp_tail = 1'b0;
    w_exp_type = FLIT_HEADER;
    case (r_state)
      ST_HEADER: begin
        w_check_en = 1'b1;
        w_exp_head = w_hdr_first;
        w_exp_tail = w_hdr_last && !w_header_next[HEADER_WIDTH-2];
      end
      ST_PAYLOAD: begin
        w_check_en = 1'b1;
        w_exp_type = FLIT_PAYLOAD;
        w_exp_tail = w_pay_last;
      end
      default: w_check_en = 1'b0;
    endcase
    w_bad      = 1'b0;
    w_bad_code = ERR_NONE;
    if (w_check_en && i_flit_valid) begin
      if (w_flit_head != w_exp_head) begin
        w_bad      = 1'b1;
        w_bad_code = ERR_UNEXPECTED_HEAD;
      end else if (w_flit_type != w_exp_type) begin
        w_bad      = 1'b1;
        w_bad_code = ERR_TYPE_MISMATCH;
      end else if (w_flit_tail != w_exp_tail) begin
        w_bad      = 1'b1;
        w_bad_code = ERR_TAIL_MISMATCH;
      end
    end
  end

  assign w_err_dest = w_flit_tail ? ST_HEADER : ST_DROP;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end else begin
      r_error <= w_err;
      if (w_err) begin
        r_error_code <= w_bad_code;
      end
    end
  end

  assign o_error      = r_error;
  assign o_error_code = r_error_code;
`else
  logic w_unused;

  assign w_bad        = 1'b0;
  assign w_err_dest   = ST_HEADER;
  assign o_error      = 1'b0;
  assign o_error_code = 2'd0;
  assign w_unused     = ^{w_flit_type, w_flit_head, w_flit_tail, w_header_next, w_hdr_first};
`endif

  assign w_err = w_bad && w_flit_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HEADER: begin
        if (w_accept) begin
          if (w_err) begin
            w_next = w_err_dest;
          end else if (w_hdr_last) begin
            w_next = ST_HDR_OUT;
          end
        end
      end
      ST_HDR_OUT: begin
        if (i_header_ready) begin
          w_next = o_header[HEADER_WIDTH-2] ? ST_PAYLOAD : ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (w_accept) begin
          if (w_err) begin
            w_next = w_err_dest;
          end else if (w_pay_last) begin
            w_next = ST_HEADER;
          end
        end
      end
`ifdef TNOC_PACKET_UNPACKER_ERROR_CHECK_EN
      ST_DROP: begin
        if (w_accept && w_flit_tail) begin
          w_next = ST_HEADER;
        end
      end
`endif
      default: w_next = ST_HEADER;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HEADER;
    end else begin
      r_state <= w_next;
    end
  end

  // Re-entering HEADER (including after a framing error there) restarts slot 0.
  assign w_hdr_wr    = w_accept && (r_state == ST_HEADER) && !w_err;
  assign w_hdr_clear = (w_next == ST_HEADER) && ((r_state != ST_HEADER) || w_err);

  assign o_flit_ready    = w_flit_ready;
  assign o_header_valid  = (r_state == ST_HDR_OUT);
  assign o_payload_valid = (r_state == ST_PAYLOAD) && i_flit_valid && !w_bad;
  assign o_payload       = w_flit_data;
  assign o_payload_last  = (r_state == ST_PAYLOAD) && w_pay_last;
  assign w_pay_xfer      = o_payload_valid && i_payload_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != ST_PAYLOAD)) begin
      r_pay_cnt <= '0;
    end else if (w_pay_xfer) begin
      r_pay_cnt <= r_pay_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tnoc_packet_unpacker.sv
// Self-checking bench for tnoc_packet_unpacker: packet-level reference model,
// vector table, randomized traffic and hand-written corner sequences.
module tb_tnoc_packet_unpacker;
  import tnoc_pkg::*;

  localparam int HW = 96;
  localparam int FW = 72;
  localparam int TW = FW + 3;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_flit_valid;
  logic          o_flit_ready;
  logic [TW-1:0] i_flit;
  logic          o_header_valid;
  logic          i_header_ready;
  logic [HW-1:0] o_header;
  logic          o_payload_valid;
  logic          i_payload_ready;
  logic [FW-1:0] o_payload;
  logic          o_payload_last;
  logic          o_error;
  logic [1:0]    o_error_code;

  always #5 clk = ~clk;

  tnoc_packet_unpacker dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_flit_valid    (i_flit_valid),
    .o_flit_ready    (o_flit_ready),
    .i_flit          (i_flit),
    .o_header_valid  (o_header_valid),
    .i_header_ready  (i_header_ready),
    .o_header        (o_header),
    .o_payload_valid (o_payload_valid),
    .i_payload_ready (i_payload_ready),
    .o_payload       (o_payload),
    .o_payload_last  (o_payload_last),
    .o_error         (o_error),
    .o_error_code    (o_error_code)
  );

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] flits_q[$];
  logic [HW-1:0] hdr_q[$];
  logic [FW:0]   pay_q[$];

  int         n_hdr, n_pay, n_last, n_err;
  logic [1:0] last_code;
  logic       tog;
  logic       hold_pend;
  logic [HW-1:0] hold_hdr;

  typedef struct {
    logic [7:0] ptype;
    logic [7:0] len;
    int         rmode;
    int         exp_pay;
    int         exp_last;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] types[5] = '{8'h20, 8'h40, 8'h60, 8'h80, 8'hC0};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [TW-1:0] mk_flit(input logic t, input logic h, input logic tl,
                                           input logic [FW-1:0] d);
    return {t, h, tl, d};
  endfunction

  // Packet model: header fields from the packet description, payload count from length.
  task automatic add_packet(input logic [7:0] ptype, input logic [7:0] len);
    logic [HW-1:0]  hdr;
    logic [143:0]   wide;
    logic [FW-1:0]  d;
    int             n;
    logic           has_pay;
    hdr = {$urandom, $urandom, $urandom};
    hdr[95:88] = ptype;
    hdr[31:24] = len;
    wide[95:0]   = hdr;
    wide[143:96] = {16'($urandom), $urandom};
    has_pay = ptype[6];
    n = has_pay ? ((len == 8'd0) ? 256 : int'(len)) : 0;
    flits_q.push_back(mk_flit(1'b0, 1'b1, 1'b0, wide[71:0]));
    flits_q.push_back(mk_flit(1'b0, 1'b0, !has_pay, wide[143:72]));
    hdr_q.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      d = {8'($urandom), $urandom, $urandom};
      flits_q.push_back(mk_flit(1'b1, 1'b0, (i == n - 1), d));
      pay_q.push_back({(i == n - 1), d});
    end
  endtask

  // rmode 0: random valid/ready; 1: valid held, payload ready toggles 1,0,1,...
  task automatic cycle(input int rmode);
    @(negedge clk);
    i_flit_valid = (flits_q.size() > 0) && ((rmode != 0) || ($urandom_range(0, 3) != 0));
    i_flit = (flits_q.size() > 0) ? flits_q[0] : TW'($urandom);
    i_header_ready = ($urandom_range(0, 2) != 0);
    if (rmode == 1) begin
      i_payload_ready = tog;
      tog = ~tog;
    end else begin
      i_payload_ready = ($urandom_range(0, 2) != 0);
    end
    #4;
    if (hold_pend) check("header_hold", {o_header_valid, o_header}, {1'b1, hold_hdr});
    hold_pend = o_header_valid && !i_header_ready;
    hold_hdr  = o_header;
    if (o_header_valid) check("ready_in_hdr_out", o_flit_ready, 1'b0);
    if (o_header_valid && i_header_ready) begin
      n_hdr++;
      if (hdr_q.size() == 0) fail("unexpected_header");
      else check("header", o_header, hdr_q.pop_front());
    end
    if (o_payload_valid && i_payload_ready) begin
      n_pay++;
      if (o_payload_last) n_last++;
      if (pay_q.size() == 0) fail("unexpected_payload");
      else check("payload", {o_payload_last, o_payload}, pay_q.pop_front());
    end
    if (o_error) begin
      n_err++;
      last_code = o_error_code;
    end
    if (i_flit_valid && o_flit_ready) void'(flits_q.pop_front());
  endtask

  task automatic run(input int rmode, input int maxc, input string name);
    int c;
    n_hdr = 0; n_pay = 0; n_last = 0; n_err = 0; last_code = 2'd0;
    tog = 1'b1;
    hold_pend = 1'b0;
    c = 0;
    while (c < maxc && (flits_q.size() > 0 || hdr_q.size() > 0 || pay_q.size() > 0)) begin
      cycle(rmode);
      c++;
    end
    repeat (3) cycle(rmode);
    if (c >= maxc) begin
      fail({name, "_timeout"});
      flits_q.delete(); hdr_q.delete(); pay_q.delete();
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_flit_valid = 1'b0;
    i_flit = '0;
    i_header_ready = 1'b0;
    i_payload_ready = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] f0, f1, f;
    logic [HW-1:0] eh;
    logic [FW:0]   p;

    vecs[0] = '{8'h20, 8'd0,   0, 0,   0};
    vecs[1] = '{8'h40, 8'd4,   1, 4,   1};
    vecs[2] = '{8'hC0, 8'd0,   0, 256, 1};
    vecs[3] = '{8'h60, 8'd1,   0, 1,   1};
    vecs[4] = '{8'h80, 8'd3,   0, 0,   0};
    vecs[5] = '{8'h40, 8'd255, 0, 255, 1};

    do_reset();
    #1;
    check("rst_flit_ready", o_flit_ready, 1'b1);
    check("rst_header_valid", o_header_valid, 1'b0);
    check("rst_payload_valid", o_payload_valid, 1'b0);
    check("rst_header", o_header, '0);
    check("rst_error", {o_error, o_error_code}, 3'd0);

    // Header latency: read packet, valid rises the cycle after the last header flit.
    add_packet(8'h20, 8'd0);
    f0 = flits_q.pop_front(); f1 = flits_q.pop_front(); eh = hdr_q.pop_front();
    @(negedge clk); i_flit_valid = 1'b1; i_flit = f0; i_header_ready = 1'b1; i_payload_ready = 1'b1;
    #4; check("lat_c1_ready", {o_flit_ready, o_header_valid}, 2'b10);
    @(negedge clk); i_flit = f1;
    #4; check("lat_c2_valid", {o_flit_ready, o_header_valid}, 2'b10);
    @(negedge clk); i_flit_valid = 1'b0;
    #4; check("lat_c3_valid", {o_flit_ready, o_header_valid}, 2'b01);
    check("lat_c3_header", o_header, eh);
    @(negedge clk);
    #4; check("lat_c4_back", {o_flit_ready, o_header_valid, o_payload_valid}, 3'b100);

    // Header held for 5 cycles while not accepted.
    add_packet(8'h80, 8'd7);
    f0 = flits_q.pop_front(); f1 = flits_q.pop_front(); eh = hdr_q.pop_front();
    @(negedge clk); i_flit_valid = 1'b1; i_flit = f0; i_header_ready = 1'b0;
    @(negedge clk); i_flit = f1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); i_flit_valid = 1'b0;
      #4; check("hold_state", {o_header_valid, o_flit_ready}, 2'b10);
      check("hold_header", o_header, eh);
    end
    @(negedge clk); i_header_ready = 1'b1;
    #4; check("hold_release", {o_header_valid, o_header}, {1'b1, eh});
    @(negedge clk);
    #4; check("hold_done", {o_header_valid, o_flit_ready}, 2'b01);

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      add_packet(vecs[v].ptype, vecs[v].len);
      run(vecs[v].rmode, 5000, "vec");
      check("vec_headers", n_hdr, 1);
      check("vec_payloads", n_pay, vecs[v].exp_pay);
      check("vec_lasts", n_last, vecs[v].exp_last);
      check("vec_no_error", n_err, 0);
    end

    // Randomized packet stream.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] t;
      t = types[$urandom_range(0, 4)];
      add_packet(t, t[6] ? 8'($urandom_range(1, 12)) : 8'($urandom_range(0, 255)));
    end
    run(0, 20000, "random");
    check("random_headers", n_hdr, 30);
    check("random_no_error", n_err, 0);

    // Reset mid-packet loses the partial packet without an error.
    add_packet(8'h40, 8'd2);
    f0 = flits_q.pop_front();
    flits_q.delete(); hdr_q.delete(); pay_q.delete();
    @(negedge clk); i_flit_valid = 1'b1; i_flit = f0; i_header_ready = 1'b0;
    @(negedge clk); i_flit_valid = 1'b0; i_rst = 1'b1;
    @(negedge clk); i_rst = 1'b0;
    #1;
    check("midrst_header", o_header, '0);
    check("midrst_ctrl", {o_flit_ready, o_header_valid, o_payload_valid, o_error, o_error_code},
          6'b100000);
    add_packet(8'h60, 8'd3);
    run(0, 2000, "after_reset");
    check("after_reset_hdr", n_hdr, 1);
    check("after_reset_pay", {n_pay, n_last}, {32'd3, 32'd1});

`ifdef TNOC_PACKET_UNPACKER_ERROR_CHECK_EN
    // Tail set on the 2nd of 4 payloads: code 3, packet cut short without last.
    add_packet(8'h40, 8'd4);
    f = flits_q[3]; f[FW] = 1'b1; flits_q[3] = f;
    void'(flits_q.pop_back()); void'(flits_q.pop_back());
    p = pay_q[0]; pay_q.delete(); pay_q.push_back(p);
    run(0, 2000, "tail_err");
    check("tail_err_count", n_err, 1);
    check("tail_err_code", last_code, 2'd3);
    check("tail_err_nolast", n_last, 0);
    add_packet(8'h40, 8'd4);
    run(0, 2000, "tail_err_next");
    check("tail_err_next", {n_err, n_pay, n_last}, {32'd0, 32'd4, 32'd1});

    // Head set on a payload flit: code 1, remaining flits dropped until tail.
    add_packet(8'h60, 8'd3);
    f = flits_q[3]; f[FW+1] = 1'b1; flits_q[3] = f;
    p = pay_q[0]; pay_q.delete(); pay_q.push_back(p);
    run(0, 2000, "head_err");
    check("head_err_count", n_err, 1);
    check("head_err_code", last_code, 2'd1);
    check("head_err_nolast", n_last, 0);
    add_packet(8'hC0, 8'd2);
    run(0, 2000, "head_err_next");
    check("head_err_next", {n_err, n_hdr, n_pay, n_last}, {32'd0, 32'd1, 32'd2, 32'd1});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
